// File: rtl/decoder_scan_if.sv
// decoder_scan_if: bus between the select-code controller and decoder_scan.
//   E     enable; 0 forces the decoder outputs inactive
//   A     N-bit select code, captured when load = 1
//   load  capture strobe for A
//   mode  0 = direct (hold captured code), 1 = self-timed scan
//   D     2^N-bit one-hot decoded output (registered)
//   idx   N-bit index of the currently active line (registered)
//   wrap  one-cycle pulse when the scan steps from the last line to line 0
// Modports: master = controller side, slave = decoder side.
interface decoder_scan_if #(
  parameter int unsigned N = 2
) ();

  localparam int unsigned W = 1 << N;

  logic         E;
  logic [N-1:0] A;
  logic         load;
  logic         mode;
  logic [W-1:0] D;
  logic [N-1:0] idx;
  logic         wrap;

  modport master (
    output E,
    output A,
    output load,
    output mode,
    input  D,
    input  idx,
    input  wrap
  );

  modport slave (
    input  E,
    input  A,
    input  load,
    input  mode,
    output D,
    output idx,
    output wrap
  );

endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot decoder with a self-timed scan
// mode that walks the active line through all 2^N outputs, holding each line
// for DWELL cycles. Used for row/column strobing and round-robin enables.
//
// Parameters:
//   N      select width, output width is 2^N (N >= 1)
//   DWELL  cycles each line stays active while scanning (DWELL >= 1)
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   bus    decoder_scan_if.slave (E, A, load, mode in; D, idx, wrap out)
// Build option:
//   DECODER_SCAN_ACTIVE_LOW_EN  when defined, D is active-low (idle level and
//                               reset value all-ones, active line driven 0).
//                               idx and wrap are unaffected.
module decoder_scan #(
  parameter int unsigned N     = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic          clk,
  input  logic          rst,
  decoder_scan_if.slave bus
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [W-1:0] D_OFF = '1;
`else
  localparam logic [W-1:0] D_OFF = '0;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;

  logic [1:0]    state,  state_nxt;
  logic [CW-1:0] cnt,    cnt_nxt;
  logic [N-1:0]  idx_q,  idx_nxt;
  logic [W-1:0]  d_q,    d_nxt;
  logic          wrap_q, wrap_nxt;

  // State and output registers; D is stored already in its output polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      d_q    <= D_OFF;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx_q  <= idx_nxt;
      d_q    <= d_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  // Next-state, next-index and dwell counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx_q;
    wrap_nxt  = 1'b0;

    if (!bus.E) begin
      // Disable overrides load and mode; idx is kept for observability.
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mode) begin
            state_nxt = SCAN;
            idx_nxt   = bus.load ? bus.A : '0;
            cnt_nxt   = '0;
          end else if (bus.load) begin
            state_nxt = HOLD;
            idx_nxt   = bus.A;
          end
        end

        HOLD: begin
          if (bus.load) begin
            idx_nxt = bus.A;
          end
          if (bus.mode) begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
          end
        end

        SCAN: begin
          if (bus.load) begin
            // A fresh code restarts the dwell and beats a coincident step.
            idx_nxt = bus.A;
            cnt_nxt = '0;
            if (!bus.mode) begin
              state_nxt = HOLD;
            end
          end else if (!bus.mode) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            cnt_nxt  = '0;
            idx_nxt  = idx_q + N'(1);
            wrap_nxt = (idx_q == '1);
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    // D always reflects the index that will be registered alongside it.
    if (state_nxt == IDLE) begin
      d_nxt = D_OFF;
    end else begin
      d_nxt = (W'(1) << idx_nxt) ^ D_OFF;
    end
  end

  assign bus.D    = d_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed plus randomized stimulus for decoder_scan (N=2,
// DWELL=3), checked each cycle against a sweep-position reference model.
// Honors DECODER_SCAN_ACTIVE_LOW_EN for the expected D polarity.
module tb_decoder_scan;

  localparam int unsigned N     = 2;
  localparam int unsigned DWELL = 3;
  localparam int unsigned W     = 1 << N;
  localparam int unsigned LINES = 1 << N;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [W-1:0] OFF = '1;
`else
  localparam logic [W-1:0] OFF = '0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decoder_scan_if #(.N(N)) bus ();

  decoder_scan #(.N(N), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: output active or not, scanning or not, and for a scan
  // the start line plus the number of cycles elapsed since that start.
  bit m_active;
  bit m_scanning;
  int m_idx;
  int m_base;
  int m_ticks;
  bit m_wrap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_d();
    logic [W-1:0] v;
    v = '0;
    if (m_active) v[m_idx] = 1'b1;
    return v ^ OFF;
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit ld, input bit md,
                            input int a);
    bit was_scanning;
    int nxt;
    if (r) begin
      m_active = 0; m_scanning = 0; m_idx = 0; m_ticks = 0; m_wrap = 0;
    end else if (!e) begin
      m_active = 0; m_scanning = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (m_active || md || ld) begin
        was_scanning = m_active && m_scanning;
        if (ld) m_idx = a;
        else if (!m_active && md) m_idx = 0;
        if (md) begin
          if (ld || !was_scanning) begin
            m_base  = m_idx;
            m_ticks = 0;
          end else begin
            m_ticks++;
            nxt = (m_base + m_ticks / DWELL) % LINES;
            m_wrap = (m_ticks % DWELL == 0) && (m_idx == LINES - 1);
            m_idx = nxt;
          end
        end
        m_active   = 1;
        m_scanning = md;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare #1 after the edge.
  task automatic step(input bit r, input bit e, input bit ld, input bit md,
                      input logic [N-1:0] a);
    rst      = r;
    bus.E    = e;
    bus.load = ld;
    bus.mode = md;
    bus.A    = a;
    @(posedge clk);
    model_edge(r, e, ld, md, int'(a));
    #1;
    check("D",    32'(bus.D),    32'(exp_d()));
    check("idx",  32'(bus.idx),  32'(m_idx));
    check("wrap", 32'(bus.wrap), 32'(m_wrap));
  endtask

  int wraps;
  int first_wrap;

  initial begin
    rst = 1'b1; bus.E = 1'b0; bus.load = 1'b0; bus.mode = 1'b0; bus.A = '0;
    #2;

    // Reset for two cycles.
    step(1, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 2'd0);
    check("rst_D",   32'(bus.D),   32'(OFF));
    check("rst_idx", 32'(bus.idx), 32'd0);

    // Direct decode of A=2.
    step(0, 1, 1, 0, 2'd2);
    check("direct_D", 32'(bus.D), 32'(4'b0100 ^ OFF));

    // Direct reload 0..3, then hold.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 2'(i));
      check("reload_D", 32'(bus.D), 32'((4'b0001 << i) ^ OFF));
    end
    step(0, 1, 0, 0, 2'd1);
    step(0, 1, 0, 0, 2'd2);
    check("hold_D", 32'(bus.D), 32'(4'b1000 ^ OFF));

    // Scan sweep from IDLE: two full sweeps, wrap at cycle 12 and 24.
    step(0, 0, 0, 0, 2'd0);
    step(0, 1, 0, 1, 2'd3);
    check("scan_start_idx", 32'(bus.idx), 32'd0);
    wraps = 0; first_wrap = -1;
    for (int i = 1; i <= 2 * DWELL * LINES; i++) begin
      step(0, 1, 0, 1, 2'd0);
      if (bus.wrap === 1'b1) begin
        wraps++;
        if (first_wrap < 0) first_wrap = i;
      end
    end
    check("wrap_count", 32'(wraps), 32'd2);
    check("first_wrap", 32'(first_wrap), 32'(DWELL * LINES));

    // Load at dwell expiry: reach idx=1 with cnt=2, then load A=3.
    step(0, 0, 0, 0, 2'd0);
    step(0, 1, 0, 1, 2'd0);
    for (int i = 0; i < DWELL + 2; i++) step(0, 1, 0, 1, 2'd0);
    check("pre_load_idx", 32'(bus.idx), 32'd1);
    step(0, 1, 1, 1, 2'd3);
    for (int i = 0; i < DWELL - 1; i++) begin
      check("load_hold_idx", 32'(bus.idx), 32'd3);
      step(0, 1, 0, 1, 2'd0);
    end
    check("load_hold_D", 32'(bus.D), 32'(4'b1000 ^ OFF));
    step(0, 1, 0, 1, 2'd0);
    check("after_load_wrap", 32'(bus.wrap), 32'd1);

    // Disable mid-scan at idx=2, then restart from 0.
    for (int i = 0; i < 2 * DWELL; i++) step(0, 1, 0, 1, 2'd0);
    check("dis_pre_idx", 32'(bus.idx), 32'd2);
    step(0, 0, 1, 1, 2'd1);
    check("dis_D",   32'(bus.D),   32'(OFF));
    check("dis_idx", 32'(bus.idx), 32'd2);
    step(0, 1, 0, 1, 2'd0);
    check("restart_idx", 32'(bus.idx), 32'd0);

    // Reset mid-scan dominates load and mode.
    step(0, 1, 0, 1, 2'd0);
    step(1, 1, 1, 1, 2'd3);
    check("midrst_D",   32'(bus.D),   32'(OFF));
    check("midrst_idx", 32'(bus.idx), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 19) != 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0,
           2'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
